seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
- REQ-001: The block SHALL have parameter DW, default 8: dividend and quotient width in bits.
- REQ-002: The block SHALL have parameter VW, default 4: divisor and remainder width in bits; VW <= DW.
- REQ-003: Port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004: Port Resetn, input, 1 bit: asynchronous reset, active-low.
- REQ-005: Port Start, input, 1 bit: request to begin a division; sampled only in IDLE.
- REQ-006: Port Dividend, input, DW bits: unsigned dividend; captured when Start is accepted.
- REQ-007: Port Divisor, input, VW bits: unsigned divisor; captured when Start is accepted.
- REQ-008: Port Quotient, output, DW bits: last completed quotient, registered.
- REQ-009: Port Remainder, output, VW bits: last completed remainder, registered.
- REQ-010: Port Busy, output, 1 bit: high while state is RUN.
- REQ-011: Port Done, output, 1 bit: one-cycle pulse, high only in state DONE.
- REQ-012: Port DivZero, output, 1 bit: set for a division with Divisor = 0; held until the next accepted Start.

Function
- REQ-013: The FSM SHALL have exactly three states, IDLE, RUN and DONE, encoded in 2 bits.
- REQ-014: In IDLE, Start = 1 at a rising edge SHALL capture Dividend and Divisor and clear DivZero.
  - Divisor nonzero: next state RUN, iteration counter = 0.
  - Divisor zero: next state DONE.
- REQ-015: In IDLE with Start = 0, the state and all outputs SHALL hold.
- REQ-016: RUN SHALL perform restoring division, one quotient bit per cycle, MSB first, for exactly DW cycles.
  - Each cycle, shift the working remainder left by one and bring in the next dividend bit.
  - Compare against the divisor; subtract if greater or equal, and shift the result bit into the quotient.
- REQ-017: The working remainder SHALL be VW+1 bits wide so the compare/subtract never overflows.
- REQ-018: After the DW-th RUN cycle the FSM SHALL enter DONE and load Quotient and Remainder in that same edge.
- REQ-019: DONE SHALL last exactly one cycle, then return unconditionally to IDLE.
- REQ-020: Latency: Start accepted at edge 0 -> Busy high in cycles 1..DW -> Done high in cycle DW+1 -> IDLE in cycle DW+2.
- REQ-021: For a divide-by-zero, Done SHALL be high in cycle 1, with Quotient = all ones, Remainder = 0 and DivZero = 1.
- REQ-022: Start asserted while in RUN or DONE SHALL be ignored: no capture, no restart, and no queuing.
- REQ-023: Changes on Dividend or Divisor after capture SHALL NOT affect the division in progress.
- REQ-024: Quotient and Remainder SHALL change only on entry to DONE, and hold at all other times.
- REQ-025: Results SHALL satisfy Dividend = Quotient*Divisor + Remainder, with Remainder < Divisor, for every nonzero divisor.
- REQ-026: Back-to-back operation: Start held high continuously SHALL be accepted in every IDLE cycle, giving one result every DW+2 cycles.

Reset
- REQ-027: Resetn = 0 SHALL immediately force:
  - state IDLE;
  - Quotient = 0, Remainder = 0;
  - Busy = 0, Done = 0, DivZero = 0;
  - counter = 0 and internal registers = 0.
- REQ-028: Reset asserted mid-RUN SHALL abort the division, with no Done pulse and no partial result on the outputs.
- REQ-029: After Resetn rises, the first rising edge with Start = 1 SHALL be accepted normally.

Verification
- REQ-030: Dividend = 200, Divisor = 7, DW = 8 -> Busy high for 8 cycles; Done in cycle 9; Quotient = 28, Remainder = 4, DivZero = 0.
- REQ-031: Dividend = 225, Divisor = 15 -> Quotient = 15, Remainder = 0. Dividend = 5, Divisor = 9 -> Quotient = 0, Remainder = 5.
- REQ-032: Dividend = 100, Divisor = 0 -> Done in cycle 1; Quotient = 8'hFF, Remainder = 0, DivZero = 1. A following valid Start clears DivZero.
- REQ-033: Start 200/7, then pulse Start with 50/2 in RUN cycle 3 -> result remains 28 rem 4, and only one Done pulse occurs.
- REQ-034: Start 255/1, then drop Resetn in RUN cycle 4 -> all outputs 0 immediately, no Done pulse. After release, 255/1 -> Quotient = 255, Remainder = 0.
- REQ-035: Exhaustive sweep, all 256 x 15 nonzero-divisor pairs with Start held high -> each result matches a reference model, one Done every 10 cycles.

Source files
------------

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Sequential unsigned restoring divider producing one quotient bit per clock,
// MSB first. A division takes DW RUN cycles plus one DONE cycle; divide-by-zero
// skips RUN and reports all-ones quotient, zero remainder and DivZero.
//
// Parameters
//   DW : dividend / quotient width in bits
//   VW : divisor / remainder width in bits (VW <= DW)
//
// Ports
//   Clock     in   rising-edge clock
//   Resetn    in   asynchronous active-low reset
//   Start     in   begin a division (only looked at in IDLE)
//   Dividend  in   [DW-1:0] unsigned dividend, captured on accepted Start
//   Divisor   in   [VW-1:0] unsigned divisor, captured on accepted Start
//   Quotient  out  [DW-1:0] last completed quotient
//   Remainder out  [VW-1:0] last completed remainder
//   Busy      out  high while dividing (state RUN)
//   Done      out  one-cycle pulse in state DONE
//   DivZero   out  last accepted division had a zero divisor
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic [DW-1:0] Dividend,
  input  logic [VW-1:0] Divisor,
  output logic [DW-1:0] Quotient,
  output logic [VW-1:0] Remainder,
  output logic          Busy,
  output logic          Done,
  output logic          DivZero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t        state_r;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after DW steps this register holds the complete quotient.
  logic [DW-1:0] dvd_r;
  logic [VW-1:0] dvs_r;
  // Partial remainder between steps; always strictly below the divisor.
  logic [VW-1:0] rem_r;
  logic [CW-1:0] cnt_r;

  // VW+1-bit working remainder: shifted partial remainder plus next dividend bit.
  logic [VW:0]   trial_s;
  logic          q_bit_s;
  logic [VW-1:0] rem_next_s;
  logic [DW-1:0] dvd_next_s;

  // One restoring-division step: shift, compare, conditionally subtract.
  always_comb begin
    trial_s    = {rem_r, dvd_r[DW-1]};
    q_bit_s    = 1'b0;
    rem_next_s = trial_s[VW-1:0];
    if (trial_s >= {1'b0, dvs_r}) begin
      q_bit_s    = 1'b1;
      // The true difference is below the divisor, so VW-bit modular
      // subtraction yields the exact result.
      rem_next_s = trial_s[VW-1:0] - dvs_r;
    end else begin
      q_bit_s    = 1'b0;
      rem_next_s = trial_s[VW-1:0];
    end
    dvd_next_s = {dvd_r[DW-2:0], q_bit_s};
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r   <= IDLE;
      dvd_r     <= '0;
      dvs_r     <= '0;
      rem_r     <= '0;
      cnt_r     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivZero   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (Start) begin
            dvd_r   <= Dividend;
            dvs_r   <= Divisor;
            rem_r   <= '0;
            cnt_r   <= '0;
            DivZero <= (Divisor == {VW{1'b0}});
            if (Divisor == {VW{1'b0}}) begin
              // Nothing to iterate: publish the saturated result at once.
              state_r   <= DONE;
              Done      <= 1'b1;
              Quotient  <= {DW{1'b1}};
              Remainder <= {VW{1'b0}};
            end else begin
              state_r <= RUN;
              Busy    <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd_r <= dvd_next_s;
          rem_r <= rem_next_s;
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == CW'(DW - 1)) begin
            // Final step: results come straight from the step logic.
            state_r   <= DONE;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            Quotient  <= dvd_next_s;
            Remainder <= rem_next_s;
          end
        end
        DONE: begin
          state_r <= IDLE;
          Done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          Busy    <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed self-checking bench for seq_divider (DW=8, VW=4). Expected results
// come from a behavioural divide model and are queued when a division is
// started, then popped and compared when Done is observed. Inputs are driven
// and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          Clock;
  logic          Resetn;
  logic          Start;
  logic [DW-1:0] Dividend;
  logic [VW-1:0] Divisor;
  logic [DW-1:0] Quotient;
  logic [VW-1:0] Remainder;
  logic          Busy;
  logic          Done;
  logic          DivZero;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q  = 8'hFF;
      e.r  = 4'd0;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = 4'(a % b);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called in cycle 1 after acceptance; returns the cycle Done was seen in.
  task automatic wait_done(output int cyc, output int busy_n);
    cyc    = 1;
    busy_n = 0;
    while (Done !== 1'b1 && cyc < 40) begin
      if (Busy === 1'b1) busy_n++;
      @(negedge Clock);
      cyc++;
    end
  endtask

  // Single division from IDLE with a one-cycle Start pulse.
  task automatic do_div(input logic [DW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
    int   cyc;
    int   busy_n;
    Start    = 1'b1;
    Dividend = a;
    Divisor  = b;
    sb.push_back(model(a, b));
    @(negedge Clock);
    Start = 1'b0;
    chk("divzero_at_accept", 32'(DivZero), (b == 4'd0) ? 32'd1 : 32'd0);
    wait_done(cyc, busy_n);
    e = sb.pop_front();
    chk("done_cycle", cyc, (b == 4'd0) ? 32'd1 : 32'(DW + 1));
    chk("busy_cycles", busy_n, (b == 4'd0) ? 32'd0 : 32'(DW));
    chk("quotient", 32'(Quotient), 32'(e.q));
    chk("remainder", 32'(Remainder), 32'(e.r));
    chk("divzero", 32'(DivZero), 32'(e.dz));
    @(negedge Clock);
    chk("done_one_cycle", 32'(Done), 32'd0);
    chk("idle_after_done", 32'(Busy), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   cyc;
    int   busy_n;
    int   dones;
    int   done_at;
    logic [DW-1:0] got_q;
    logic [VW-1:0] got_r;

    Resetn   = 1'b0;
    Start    = 1'b0;
    Dividend = 8'd0;
    Divisor  = 4'd0;
    repeat (2) @(negedge Clock);
    chk("reset_quotient", 32'(Quotient), 32'd0);
    chk("reset_remainder", 32'(Remainder), 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_divzero", 32'(DivZero), 32'd0);
    Resetn = 1'b1;
    @(negedge Clock);

    // Basic divisions, exact and divisor-larger-than-dividend cases.
    do_div(8'd200, 4'd7);
    do_div(8'd225, 4'd15);
    do_div(8'd5, 4'd9);

    // Divide by zero, sticky flag while idle, cleared by the next start.
    do_div(8'd100, 4'd0);
    repeat (3) @(negedge Clock);
    chk("divzero_held", 32'(DivZero), 32'd1);
    chk("quotient_held", 32'(Quotient), 32'hFF);
    do_div(8'd5, 4'd9);

    // Start pulse with new operands during RUN must be ignored.
    Start    = 1'b1;
    Dividend = 8'd200;
    Divisor  = 4'd7;
    sb.push_back(model(8'd200, 4'd7));
    @(negedge Clock);
    Start = 1'b0;
    repeat (2) @(negedge Clock);
    chk("quotient_hold_in_run", 32'(Quotient), 32'd0);
    chk("remainder_hold_in_run", 32'(Remainder), 32'd5);
    Start    = 1'b1;
    Dividend = 8'd50;
    Divisor  = 4'd2;
    @(negedge Clock);
    Start   = 1'b0;
    dones   = 0;
    done_at = 0;
    got_q   = 8'd0;
    got_r   = 4'd0;
    for (int c = 4; c <= 16; c++) begin
      if (Done === 1'b1) begin
        dones++;
        done_at = c;
        got_q   = Quotient;
        got_r   = Remainder;
      end
      @(negedge Clock);
    end
    e = sb.pop_front();
    chk("ignore_start_done_count", dones, 32'd1);
    chk("ignore_start_done_cycle", done_at, 32'(DW + 1));
    chk("ignore_start_quotient", 32'(got_q), 32'(e.q));
    chk("ignore_start_remainder", 32'(got_r), 32'(e.r));
    chk("ignore_start_no_requeue", 32'(Busy), 32'd0);

    // Reset in RUN cycle 4 aborts without a Done pulse.
    Start    = 1'b1;
    Dividend = 8'd255;
    Divisor  = 4'd1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    chk("busy_before_reset", 32'(Busy), 32'd1);
    #2 Resetn = 1'b0;
    #1;
    chk("abort_quotient", 32'(Quotient), 32'd0);
    chk("abort_remainder", 32'(Remainder), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_divzero", 32'(DivZero), 32'd0);
    dones = 0;
    repeat (3) begin
      @(negedge Clock);
      if (Done === 1'b1) dones++;
    end
    chk("abort_no_done", dones, 32'd0);
    Resetn = 1'b1;
    do_div(8'd255, 4'd1);

    // Exhaustive sweep with Start held high: one result every DW+2 cycles.
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        Dividend = 8'(a);
        Divisor  = 4'(b);
        Start    = 1'b1;
        sb.push_back(model(8'(a), 4'(b)));
        @(negedge Clock);
        wait_done(cyc, busy_n);
        e = sb.pop_front();
        chk("sweep_result", 32'({Quotient, Remainder, DivZero}), 32'(e));
        chk("sweep_period", cyc + 1, 32'(DW + 2));
        @(negedge Clock);
      end
    end
    Start = 1'b0;
    repeat (2) @(negedge Clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
